// File: rtl/exibe_sequencia.sv
// Memory-game presentation side: reads the stored sequence from synchronous memory
// and plays entries 0..limite on the LEDs with fixed on/blank timing.
`timescale 1ns/1ps
module exibe_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] ON_FIM  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_FIM = TW'(T_OFF - 1);

    localparam logic [3:0] OCIOSO  = 4'd0;
    localparam logic [3:0] BUSCA   = 4'd1;
    localparam logic [3:0] CARREGA = 4'd2;
    localparam logic [3:0] MOSTRA  = 4'd3;
    localparam logic [3:0] APAGA   = 4'd4;
    localparam logic [3:0] FIM     = 4'd5;

    logic [3:0]    r_estado;
    logic [3:0]    r_endereco;
    logic [3:0]    r_leds;
    logic [3:0]    r_limite;
    logic [TW-1:0] r_timer;

    logic w_fim_on;
    logic w_fim_off;
    logic w_ultimo;

    assign w_fim_on  = (r_timer == ON_FIM);
    assign w_fim_off = (r_timer == OFF_FIM);
    assign w_ultimo  = (r_endereco == r_limite);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_endereco <= '0;
            r_leds     <= '0;
            r_limite   <= '0;
            r_timer    <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_limite   <= limite;
                        r_endereco <= '0;
                        r_estado   <= BUSCA;
                    end
                end
                // memory registers its data at the edge leaving BUSCA
                BUSCA: r_estado <= CARREGA;
                CARREGA: begin
                    r_leds   <= mem_dado;
                    r_timer  <= '0;
                    r_estado <= MOSTRA;
                end
                MOSTRA: begin
                    if (w_fim_on) begin
                        r_leds   <= '0;
                        r_timer  <= '0;
                        r_estado <= APAGA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                APAGA: begin
                    if (w_fim_off) begin
                        r_timer <= '0;
                        if (w_ultimo) begin
                            r_estado <= FIM;
                        end else begin
                            r_endereco <= r_endereco + 4'd1;
                            r_estado   <= BUSCA;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                FIM: r_estado <= OCIOSO;
                default: begin
                    r_estado <= OCIOSO;
                    r_leds   <= '0;
                    r_timer  <= '0;
                end
            endcase
        end
    end

    assign mem_endereco = r_endereco;
    assign leds         = r_leds;
    assign exibindo     = (r_estado != OCIOSO);
    assign pronto       = (r_estado == FIM);
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: closed-form expected trace per cycle, scoreboard queue,
// a hand-written vector table for back-to-back runs, and an async-reset sequence.
`timescale 1ns/1ps
module tb_exibe_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int PER   = 2 + T_ON + T_OFF;

    typedef struct {
        logic [3:0] st;
        logic [3:0] led;
        logic [3:0] adr;
        logic       pr;
        logic       ex;
    } exp_t;

    typedef struct {
        logic       ini;
        logic [3:0] lim;
        exp_t       e;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] mem_dado = 4'd0;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];
    exp_t       q[$];
    vec_t       tbl [20];
    int         total = 0;
    int         bad   = 0;
    int         ck    = 0;

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .mem_dado     (mem_dado),
        .mem_endereco (mem_endereco),
        .leds         (leds),
        .exibindo     (exibindo),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // synchronous sequence memory
    always @(posedge clock) mem_dado <= mem[mem_endereco];

    task automatic chk(input string nm, input int k, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, want);
        end
    endtask

    function automatic exp_t mk_e(input int st, input int led, input int adr, input int pr, input int ex);
        exp_t e;
        e.st  = 4'(st);
        e.led = 4'(led);
        e.adr = 4'(adr);
        e.pr  = 1'(pr);
        e.ex  = 1'(ex);
        return e;
    endfunction

    function automatic vec_t mk(input int ini, input int st, input int led, input int pr, input int ex);
        vec_t v;
        v.ini = 1'(ini);
        v.lim = 4'd0;
        v.e   = mk_e(st, led, 0, pr, ex);
        return v;
    endfunction

    // expected outputs k cycles after the edge that samples iniciar, for limite L
    function automatic exp_t model(input int k, input int L);
        int n, e, p;
        n = PER * (L + 1);
        if (k < n) begin
            e = k / PER;
            p = k % PER;
            if (p == 0)          return mk_e(1, 0, e, 0, 1);
            else if (p == 1)     return mk_e(2, 0, e, 0, 1);
            else if (p < 2+T_ON) return mk_e(3, int'(mem[e]), e, 0, 1);
            else                 return mk_e(4, 0, e, 0, 1);
        end else if (k == n) begin
            return mk_e(5, 0, L, 1, 1);
        end
        return mk_e(0, 0, L, 0, 0);
    endfunction

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("estado",   ck, db_estado,          e.st);
            chk("leds",     ck, leds,               e.led);
            chk("endereco", ck, mem_endereco,       e.adr);
            chk("pronto",   ck, {3'b000, pronto},   {3'b000, e.pr});
            chk("exibindo", ck, {3'b000, exibindo}, {3'b000, e.ex});
            ck++;
        end
    end

    task automatic play(input int L, input int rep_k, input int chg_k, input int newlim, input int stop_k);
        int n, last;
        n    = PER * (L + 1);
        last = (stop_k >= 0) ? stop_k : n + 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            iniciar = (k == 0) || (k == rep_k);
            if (k == 0) limite = 4'(L);
            else if (k == chg_k) limite = 4'(newlim);
            q.push_back(model(k, L));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd5, 4'd0, 4'd15,
                4'd9, 4'd6, 4'd10, 4'd12, 4'd7, 4'd11, 4'd13, 4'd14};

        // back-to-back runs with iniciar held high, limite=0
        tbl[0]  = mk(1, 1, 0, 0, 1);
        tbl[1]  = mk(1, 2, 0, 0, 1);
        tbl[2]  = mk(1, 3, 1, 0, 1);
        tbl[3]  = mk(1, 3, 1, 0, 1);
        tbl[4]  = mk(1, 3, 1, 0, 1);
        tbl[5]  = mk(1, 4, 0, 0, 1);
        tbl[6]  = mk(1, 4, 0, 0, 1);
        tbl[7]  = mk(1, 5, 0, 1, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 1);
        tbl[10] = mk(1, 2, 0, 0, 1);
        tbl[11] = mk(1, 3, 1, 0, 1);
        tbl[12] = mk(1, 3, 1, 0, 1);
        tbl[13] = mk(1, 3, 1, 0, 1);
        tbl[14] = mk(1, 4, 0, 0, 1);
        tbl[15] = mk(1, 4, 0, 0, 1);
        tbl[16] = mk(1, 5, 0, 1, 1);
        tbl[17] = mk(0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0);

        reset   = 1'b0;
        iniciar = 1'b0;
        limite  = 4'd0;
        #2;
        chk("rst_estado",   -1, db_estado,          4'd0);
        chk("rst_leds",     -1, leds,               4'd0);
        chk("rst_endereco", -1, mem_endereco,       4'd0);
        chk("rst_pronto",   -1, {3'b000, pronto},   4'd0);
        chk("rst_exibindo", -1, {3'b000, exibindo}, 4'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        play(3, -1, -1, 0, -1);
        play(0, -1, -1, 0, -1);
        play(15, -1, -1, 0, -1);
        // re-pulse iniciar in MOSTRA and shrink limite mid-run
        play(2, 3, 4, 0, -1);
        drain();

        // async reset while entry 2 (value 4) is on the leds
        play(3, -1, -1, 0, 2*PER + 3);
        drain();
        chk("pre_rst_leds",  -2, leds,      4'd4);
        chk("pre_rst_state", -2, db_estado, 4'd3);
        reset = 1'b0;
        #1;
        chk("async_leds",     -3, leds,               4'd0);
        chk("async_exibindo", -3, {3'b000, exibindo}, 4'd0);
        chk("async_estado",   -3, db_estado,          4'd0);
        chk("async_endereco", -3, mem_endereco,       4'd0);
        @(negedge clock);
        reset   = 1'b1;
        iniciar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            q.push_back(mk_e(0, 0, 0, 0, 0));
        end
        drain();

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            iniciar = tbl[i].ini;
            limite  = tbl[i].lim;
            q.push_back(tbl[i].e);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
